// File: rtl/dkong3_dmc_arbiter.sv
// Arbitrates two DMC DMA fetch requesters onto one shared, fixed-latency DMC ROM read port.
// Grants round-robin on ties and returns the fetched byte with a hold-until-release acknowledge.
module dkong3_dmc_arbiter #(
    parameter int ROM_AW      = 13,
    parameter int ROM_LATENCY = 1
) (
    input  logic              I_SUBCLK,
    input  logic              I_SUB_RESETn,
    input  logic              I_REQ1,
    input  logic [15:0]       I_ADDR1,
    output logic              O_ACK1,
    output logic [7:0]        O_DATA1,
    input  logic              I_REQ2,
    input  logic [15:0]       I_ADDR2,
    output logic              O_ACK2,
    output logic [7:0]        O_DATA2,
    output logic [ROM_AW-1:0] O_ROM_ADDR,
    input  logic [7:0]        I_ROM_DO,
    output logic              O_BUSY,
    output logic              O_GNT2
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_ACK   = 2'd2;

    logic [1:0] state;
    logic [1:0] lat_cnt;
    logic       last_gnt2;
    logic       win2;
    logic       owner_req;

    // Requester 2 wins when it is alone, or on a tie when requester 2 was not served last.
    always_comb begin
        win2      = I_REQ2 & (~I_REQ1 | ~last_gnt2);
        owner_req = O_GNT2 ? I_REQ2 : I_REQ1;
    end

    generate
        if (ROM_AW < 16) begin : g_unused
            logic unused_addr_hi;
            assign unused_addr_hi = ^{I_ADDR1[15:ROM_AW], I_ADDR2[15:ROM_AW]};
        end
    endgenerate

    always_ff @(posedge I_SUBCLK) begin
        if (!I_SUB_RESETn) begin
            state      <= ST_IDLE;
            lat_cnt    <= '0;
            last_gnt2  <= 1'b1;
            O_ACK1     <= 1'b0;
            O_ACK2     <= 1'b0;
            O_DATA1    <= '0;
            O_DATA2    <= '0;
            O_ROM_ADDR <= '0;
            O_BUSY     <= 1'b0;
            O_GNT2     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (I_REQ1 || I_REQ2) begin
                        O_GNT2     <= win2;
                        last_gnt2  <= win2;
                        O_ROM_ADDR <= win2 ? I_ADDR2[ROM_AW-1:0] : I_ADDR1[ROM_AW-1:0];
                        lat_cnt    <= 2'(ROM_LATENCY);
                        O_BUSY     <= 1'b1;
                        state      <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // Capture one edge after the counter has run down, so the ROM output has settled.
                    if (lat_cnt == 2'd0) begin
                        if (O_GNT2) begin
                            O_DATA2 <= I_ROM_DO;
                            O_ACK2  <= 1'b1;
                        end else begin
                            O_DATA1 <= I_ROM_DO;
                            O_ACK1  <= 1'b1;
                        end
                        state <= ST_ACK;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                ST_ACK: begin
                    if (!owner_req) begin
                        O_ACK1 <= 1'b0;
                        O_ACK2 <= 1'b0;
                        O_BUSY <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    O_ACK1 <= 1'b0;
                    O_ACK2 <= 1'b0;
                    O_BUSY <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dkong3_dmc_arbiter.sv
// Bench for dkong3_dmc_arbiter: latency 1 and latency 3 instances share stimulus and are
// compared every cycle against a transaction-level model, plus directed vectors and sequences.
module tb_dkong3_dmc_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, req1, req2;
    logic [15:0] addr1, addr2;

    logic        ack1_a, ack2_a, busy_a, gnt2_a;
    logic [7:0]  data1_a, data2_a, rom_do_a;
    logic [12:0] rom_addr_a;
    logic        ack1_b, ack2_b, busy_b, gnt2_b;
    logic [7:0]  data1_b, data2_b, rom_do_b;
    logic [12:0] rom_addr_b;

    int errors = 0;
    int checks = 0;

    dkong3_dmc_arbiter #(.ROM_AW(13), .ROM_LATENCY(1)) dut_a (
        .I_SUBCLK(clk), .I_SUB_RESETn(rstn),
        .I_REQ1(req1), .I_ADDR1(addr1), .O_ACK1(ack1_a), .O_DATA1(data1_a),
        .I_REQ2(req2), .I_ADDR2(addr2), .O_ACK2(ack2_a), .O_DATA2(data2_a),
        .O_ROM_ADDR(rom_addr_a), .I_ROM_DO(rom_do_a), .O_BUSY(busy_a), .O_GNT2(gnt2_a)
    );

    dkong3_dmc_arbiter #(.ROM_AW(13), .ROM_LATENCY(3)) dut_b (
        .I_SUBCLK(clk), .I_SUB_RESETn(rstn),
        .I_REQ1(req1), .I_ADDR1(addr1), .O_ACK1(ack1_b), .O_DATA1(data1_b),
        .I_REQ2(req2), .I_ADDR2(addr2), .O_ACK2(ack2_b), .O_DATA2(data2_b),
        .O_ROM_ADDR(rom_addr_b), .I_ROM_DO(rom_do_b), .O_BUSY(busy_b), .O_GNT2(gnt2_b)
    );

    // Synchronous ROMs with 1 and 3 register stages.
    logic [7:0] rom [8192];
    logic [7:0] pipe_a;
    logic [7:0] pipe_b [3];
    always @(posedge clk) begin
        pipe_a    <= rom[rom_addr_a];
        pipe_b[0] <= rom[rom_addr_b];
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign rom_do_a = pipe_a;
    assign rom_do_b = pipe_b[2];

    // Transaction-level reference: a grant at edge G completes at absolute edge G+lat+1.
    typedef struct {
        bit          busy;
        bit          owner2;
        bit          acked;
        bit          last2;
        int          ack_at;
        logic [12:0] addr;
        logic [7:0]  d1;
        logic [7:0]  d2;
    } model_t;

    model_t ma, mb;
    int     cyc = 0;
    bit     chk_en = 1'b0;

    function automatic model_t step(model_t m, int lat, int now);
        bit w2;
        if (!rstn) begin
            m = '{default: 0};
            m.last2 = 1'b1;
        end else if (!m.busy) begin
            if (req1 || req2) begin
                w2 = (req1 && req2) ? !m.last2 : req2;
                m.owner2 = w2;
                m.last2  = w2;
                m.addr   = w2 ? addr2[12:0] : addr1[12:0];
                m.busy   = 1'b1;
                m.acked  = 1'b0;
                m.ack_at = now + lat + 1;
            end
        end else if (!m.acked) begin
            if (now == m.ack_at) begin
                m.acked = 1'b1;
                if (m.owner2) m.d2 = rom[m.addr];
                else          m.d1 = rom[m.addr];
            end
        end else if (!(m.owner2 ? req2 : req1)) begin
            m.acked = 1'b0;
            m.busy  = 1'b0;
        end
        return m;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!rstn) chk_en = 1'b1;
        ma = step(ma, 1, cyc);
        mb = step(mb, 3, cyc);
    end

    task automatic cmp_model(input string nm, input model_t m, input logic a1, input logic a2,
                             input logic bz, input logic g2, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [12:0] ra);
        logic e1, e2;
        e1 = m.acked && !m.owner2;
        e2 = m.acked && m.owner2;
        checks++;
        if (a1 !== e1 || a2 !== e2 || bz !== m.busy || (m.busy && g2 !== m.owner2) ||
            d1 !== m.d1 || d2 !== m.d2 || ra !== m.addr || (a1 && a2)) begin
            errors++;
            $display("FAIL %s cyc=%0d got ack=%b%b busy=%b gnt2=%b d1=%h d2=%h ra=%h want ack=%b%b busy=%b gnt2=%b d1=%h d2=%h ra=%h",
                     nm, cyc, a1, a2, bz, g2, d1, d2, ra, e1, e2, m.busy, m.owner2, m.d1, m.d2, m.addr);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_model("model_lat1", ma, ack1_a, ack2_a, busy_a, gnt2_a, data1_a, data2_a, rom_addr_a);
            cmp_model("model_lat3", mb, ack1_b, ack2_b, busy_b, gnt2_b, data1_b, data2_b, rom_addr_b);
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy_a || busy_b) && n < 30) begin
            tick();
            n++;
        end
        check("wait_idle_timeout", {31'd0, busy_a | busy_b}, 32'd0);
    endtask

    typedef struct {
        bit          rst_n, r1, r2;
        logic [15:0] a1, a2;
        bit          ack1, ack2, busy, gnt2;
        logic [12:0] ra;
        logic [7:0]  d1, d2;
    } vec_t;

    vec_t vt[15];

    initial begin
        int   order[$];
        int   pulses;
        logic [7:0] r10, r20;

        for (int i = 0; i < 8192; i++) rom[i] = 8'(i * 37 + (i >> 4));
        rom[13'h0123] = 8'h5A;
        rom[13'h0AAA] = 8'hC3;
        rom[13'h1555] = 8'h3C;
        r10 = rom[13'h0010];
        r20 = rom[13'h0020];

        rstn = 1'b0; req1 = 1'b0; req2 = 1'b0; addr1 = '0; addr2 = '0;

        //          rst r1 r2 a1        a2        ack1 ack2 busy gnt2 ra        d1     d2
        vt[0]  = '{0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 13'h0000, 8'h00, 8'h00};
        vt[1]  = '{1, 1, 0, 16'hA123, 16'h0000, 0, 0, 1, 0, 13'h0123, 8'h00, 8'h00};
        vt[2]  = '{1, 1, 0, 16'hA123, 16'h0000, 0, 0, 1, 0, 13'h0123, 8'h00, 8'h00};
        vt[3]  = '{1, 1, 0, 16'hA123, 16'h0000, 1, 0, 1, 0, 13'h0123, 8'h5A, 8'h00};
        vt[4]  = '{1, 1, 0, 16'hA123, 16'h0000, 1, 0, 1, 0, 13'h0123, 8'h5A, 8'h00};
        vt[5]  = '{1, 0, 0, 16'hA123, 16'h0000, 0, 0, 0, 0, 13'h0123, 8'h5A, 8'h00};
        vt[6]  = '{0, 1, 1, 16'h8010, 16'h8020, 0, 0, 0, 0, 13'h0000, 8'h00, 8'h00};
        vt[7]  = '{1, 1, 1, 16'h8010, 16'h8020, 0, 0, 1, 0, 13'h0010, 8'h00, 8'h00};
        vt[8]  = '{1, 1, 1, 16'h8010, 16'h8020, 0, 0, 1, 0, 13'h0010, 8'h00, 8'h00};
        vt[9]  = '{1, 1, 1, 16'h8010, 16'h8020, 1, 0, 1, 0, 13'h0010, r10,   8'h00};
        vt[10] = '{1, 0, 1, 16'h8010, 16'h8020, 0, 0, 0, 0, 13'h0010, r10,   8'h00};
        vt[11] = '{1, 0, 1, 16'h8010, 16'h8020, 0, 0, 1, 1, 13'h0020, r10,   8'h00};
        vt[12] = '{1, 0, 1, 16'h8010, 16'h8020, 0, 0, 1, 1, 13'h0020, r10,   8'h00};
        vt[13] = '{1, 0, 1, 16'h8010, 16'h8020, 0, 1, 1, 1, 13'h0020, r10,   r20};
        vt[14] = '{1, 0, 0, 16'h8010, 16'h8020, 0, 0, 0, 1, 13'h0020, r10,   r20};

        foreach (vt[i]) begin
            rstn = vt[i].rst_n; req1 = vt[i].r1; req2 = vt[i].r2;
            addr1 = vt[i].a1; addr2 = vt[i].a2;
            tick();
            checks++;
            if (ack1_a !== vt[i].ack1 || ack2_a !== vt[i].ack2 || busy_a !== vt[i].busy ||
                (vt[i].busy && gnt2_a !== vt[i].gnt2) || rom_addr_a !== vt[i].ra ||
                data1_a !== vt[i].d1 || data2_a !== vt[i].d2) begin
                errors++;
                $display("FAIL vec%0d got ack=%b%b busy=%b gnt2=%b ra=%h d1=%h d2=%h want ack=%b%b busy=%b gnt2=%b ra=%h d1=%h d2=%h",
                         i, ack1_a, ack2_a, busy_a, gnt2_a, rom_addr_a, data1_a, data2_a,
                         vt[i].ack1, vt[i].ack2, vt[i].busy, vt[i].gnt2, vt[i].ra, vt[i].d1, vt[i].d2);
            end
        end
        wait_idle();

        // Round-robin with both requesters re-requesting immediately after each acknowledge.
        rstn = 1'b0; tick(); rstn = 1'b1;
        req1 = 1'b1; req2 = 1'b1; addr1 = 16'h0100; addr2 = 16'h0200;
        for (int c = 0; c < 80 && order.size() < 4; c++) begin
            tick();
            if (ack1_a) order.push_back(1);
            if (ack2_a) order.push_back(2);
            req1 = !ack1_a;
            req2 = !ack2_a;
        end
        check("rr_grant_count", order.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < order.size()) check($sformatf("rr_order%0d", k), order[k], (k % 2 == 0) ? 1 : 2);
        end
        req1 = 1'b0; req2 = 1'b0;
        wait_idle();
        tick();

        // Requester 2 drops after one cycle: single-cycle acknowledge, valid data.
        req2 = 1'b1; addr2 = 16'h1234;
        tick();
        req2 = 1'b0;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (ack2_a) pulses++;
        end
        check("early_drop_pulses", pulses, 1);
        check("early_drop_data", data2_a, rom[13'h1234]);
        check("early_drop_idle", busy_a, 1'b0);
        wait_idle();
        tick();

        // Reset one cycle after a grant aborts the fetch and restores requester-1 tie priority.
        req1 = 1'b1; req2 = 1'b1; addr1 = 16'h0300; addr2 = 16'h0400;
        tick();
        check("rst_fetch_busy_before", busy_a, 1'b1);
        rstn = 1'b0;
        tick();
        check("rst_fetch_outputs", {ack1_a, ack2_a, busy_a, gnt2_a, rom_addr_a, data1_a, data2_a}, '0);
        rstn = 1'b1;
        tick();
        check("rst_tie_winner", {busy_a, gnt2_a}, 2'b10);
        req1 = 1'b0; req2 = 1'b0;
        wait_idle();
        tick();

        // Latency 3: acknowledge after E0+4; a later address change is ignored.
        rstn = 1'b0; tick(); rstn = 1'b1;
        req1 = 1'b1; addr1 = 16'hEAAA;
        tick();
        addr1 = 16'h1555;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("lat3_ack_e%0d", k), ack1_b, (k == 4) ? 1'b1 : 1'b0);
            check($sformatf("lat3_addr_e%0d", k), rom_addr_b, 13'h0AAA);
        end
        check("lat3_data", data1_b, 8'hC3);
        req1 = 1'b0;
        wait_idle();

        // Random traffic, checked every cycle against the model for both latencies.
        for (int c = 0; c < 3000; c++) begin
            rstn  = ($urandom_range(0, 149) != 0);
            req1  = ($urandom_range(0, 9) < 6);
            req2  = ($urandom_range(0, 9) < 6);
            addr1 = 16'($urandom);
            addr2 = 16'($urandom);
            tick();
        end
        req1 = 1'b0; req2 = 1'b0; rstn = 1'b1;
        wait_idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
